nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder/subtractor that processes one 4-bit nibble per clock, LSB nibble first.
- For each nibble it generates g = a&b and p = a^b, then passes g, p and the registered carry to the team's 4-bit carry-lookahead unit (cll_4bit: g[3:0], p[3:0], cin -> cout[3:0]).
- It consumes cout[3] as the next nibble's carry-in.
- It sits upstream and downstream of cll_4bit in the datapath, and is used where area matters more than single-cycle add latency.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 4 and at least 8.
- NNIB (localparam), WIDTH/4, number of nibble cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result; held until the next accepted start.
- cout  output  1  carry out of bit WIDTH-1 (for subtract: 1 = no borrow).
- overflow  output  1  signed overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high.
- Reset (asynchronous, any state): state = IDLE; busy = 0, done = 0, sum = 0, cout = 0, overflow = 0; nibble counter = 0; carry register = 0. Any operation in progress is abandoned and no done is produced.
- States:
  - IDLE, RUN, DONE. All outputs are registered.
- start is accepted at a clock edge when state is IDLE or DONE. On acceptance:
  - latch opA = a, opB = sub ? ~b : b, carry = sub;
  - clear the counter; state -> RUN; busy = 1.
- start while in RUN is ignored. It is not queued, and the latched operands and sub are unaffected.
- RUN, edge k (k = 0..NNIB-1), nibble k:
  - g = opA[4k+3:4k] & opB[4k+3:4k];
  - p = opA[4k+3:4k] ^ opB[4k+3:4k];
  - cin = carry.
  - Sum nibble = p ^ {cout[2:0], cin}; it is written into sum[4k+3:4k].
  - carry <= cout[3]. The counter increments.
- Edge of the last nibble (k = NNIB-1): also
  - cout <= cout[3];
  - overflow <= cout[3] ^ cout[2];
  - done <= 1, busy <= 0; state -> DONE.
- DONE: done is high for exactly this one cycle. At the next edge state -> IDLE and done -> 0, unless start is asserted, in which case the new operation is accepted (back-to-back).
- Latency: start sampled at edge E0, nibble 0 at E1, done high after edge E(NNIB). That is 8 edges for WIDTH = 32; throughput is one operation per NNIB+1 cycles max.
- sum, cout and overflow: stable from done until the next accepted start. During RUN, the sum nibbles not yet written may hold stale values and are not valid.
- Arithmetic is modulo 2^WIDTH. Subtract is implemented as a + ~b + 1.
- Changes on a, b or sub after acceptance have no effect.

Test Plan:
- Reset mid-operation: assert reset at edge E3 of an add of 0x12345678 + 0x11111111 -> all outputs 0 immediately (asynchronous), no done pulse; a fresh start after reset is released produces the correct 0x23456789.
- Full carry ripple: a = 0xFFFFFFFF, b = 0x00000001, sub = 0 -> done exactly 8 edges after start, busy high for edges 1..7 window; sum = 0x00000000, cout = 1, overflow = 0.
- Signed overflow on add: 0x7FFFFFFF + 0x00000001 -> sum = 0x80000000, cout = 0, overflow = 1.
- Subtract:
  - 5 - 7 -> sum = 0xFFFFFFFE, cout = 0, overflow = 0;
  - 0x80000000 - 1 -> sum = 0x7FFFFFFF, cout = 1, overflow = 1.
- Handshake:
  - start pulsed during RUN with different operands is ignored, and the original result is returned;
  - start held in the DONE cycle is accepted back-to-back, with the second done arriving NNIB+1 edges after the first;
  - sum stays stable while idle for 20 cycles.
- Random: 2000 random a/b/sub pairs against a reference model (a ± b, carry, signed overflow), checked at every done. Also rerun with WIDTH = 8 and WIDTH = 16.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Area-lean WIDTH-bit adder/subtractor: one 4-bit nibble per clock, LSB first,
// with the nibble carries produced by a 4-bit carry-lookahead unit.

module cll_4bit (
    input  logic [3:0] g,
    input  logic [3:0] p,
    input  logic       cin,
    output logic [3:0] cout
);
    assign cout[0] = g[0] | (p[0] & cin);
    assign cout[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign cout[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                   | (p[2] & p[1] & p[0] & cin);
    assign cout[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NNIB = WIDTH / 4;
    localparam int CW   = $clog2(NNIB);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [NNIB-1:0][3:0] opa, opb, sum_r;
    logic                carry;
    logic [CW-1:0]       cnt;
    logic [3:0]          nib_a, nib_b, g, p, cl;
    logic                last;

    assign nib_a = opa[cnt];
    assign nib_b = opb[cnt];
    assign g     = nib_a & nib_b;
    assign p     = nib_a ^ nib_b;
    assign last  = (cnt == CW'(NNIB - 1));
    assign sum   = sum_r;

    cll_4bit u_cll (
        .g    (g),
        .p    (p),
        .cin  (carry),
        .cout (cl)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum_r    <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            cnt      <= '0;
            carry    <= 1'b0;
            opa      <= '0;
            opb      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // subtract is a + ~b + 1: the +1 enters as nibble-0 carry-in
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum_r[cnt] <= p ^ {cl[2:0], carry};
                    carry      <= cl[3];
                    cnt        <= cnt + 1'b1;
                    if (last) begin
                        cout     <= cl[3];
                        overflow <= cl[3] ^ cl[2];
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random checks of nibble_serial_adder at WIDTH 32, plus 8/16.
module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        reset, start, sub;
    logic [31:0] a, b, sum;
    logic        busy, done, cout, overflow;

    logic        start_s, sub_s;
    logic [15:0] a_s, b_s, sum16;
    logic [7:0]  sum8;
    logic        busy8, done8, cout8, ov8;
    logic        busy16, done16, cout16, ov16;

    int          checks = 0;
    int          failures = 0;
    int          n, l8, l16;
    bit          bok, seen, stable;
    logic [31:0] ra, rb, bb, s0;
    logic        rs, rov;
    logic [32:0] mdl;
    logic [8:0]  e8;
    logic [16:0] e16;
    logic [7:0]  bb8;
    logic [15:0] bb16;
    logic        eov8, eov16;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
    );

    nibble_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start_s), .sub(sub_s), .a(a_s[7:0]), .b(b_s[7:0]),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ov8)
    );

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start_s), .sub(sub_s), .a(a_s), .b(b_s),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .overflow(ov16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a request so the next rising edge accepts it, then drop start.
    task automatic launch(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count edges after acceptance until done; optionally pulse start mid-run.
    task automatic wait_done(output int cnt_o, input int inj, output bit busy_ok);
        int k;
        k = 0;
        busy_ok = (busy === 1'b1);
        while (k < 20) begin
            @(posedge clk); #1;
            k++;
            if (k == inj) begin
                start = 1'b1; a = 32'hDEADBEEF; b = 32'h12345678; sub = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) break;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        cnt_o = k;
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                          input int inj, output int cnt_o, output bit busy_ok);
        @(negedge clk);
        launch(ta, tb_v, ts);
        wait_done(cnt_o, inj, busy_ok);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        start_s = 1'b0; sub_s = 1'b0; a_s = '0; b_s = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum", sum, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_sum8", sum8, 0);
        chk("rst_done16", done16, 0);
        reset = 1'b0;

        // Full carry ripple
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, n, bok);
        chk("ripple_lat", n, 8);
        chk("ripple_busy_run", bok, 1);
        chk("ripple_busy_done", busy, 0);
        chk("ripple_sum", sum, 32'h0);
        chk("ripple_cout", cout, 1);
        chk("ripple_ovf", overflow, 0);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);

        // Signed overflow on add
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, n, bok);
        chk("addovf_sum", sum, 32'h80000000);
        chk("addovf_cout", cout, 0);
        chk("addovf_ovf", overflow, 1);

        // Subtract
        run_op(32'd5, 32'd7, 1'b1, 0, n, bok);
        chk("sub57_sum", sum, 32'hFFFFFFFE);
        chk("sub57_cout", cout, 0);
        chk("sub57_ovf", overflow, 0);
        run_op(32'h80000000, 32'h1, 1'b1, 0, n, bok);
        chk("submin_sum", sum, 32'h7FFFFFFF);
        chk("submin_cout", cout, 1);
        chk("submin_ovf", overflow, 1);

        // start during RUN is ignored
        run_op(32'h10, 32'h20, 1'b0, 3, n, bok);
        chk("ign_lat", n, 8);
        chk("ign_sum", sum, 32'h30);
        chk("ign_cout", cout, 0);

        // Back-to-back: start held in the DONE cycle
        run_op(32'd100, 32'd23, 1'b0, 0, n, bok);
        chk("b2b1_sum", sum, 32'h7B);
        launch(32'd1000, 32'd1, 1'b1);
        wait_done(n, 0, bok);
        chk("b2b_gap", n + 1, 9);
        chk("b2b2_sum", sum, 32'h3E7);
        chk("b2b2_cout", cout, 1);

        // Idle stability with inputs wiggling
        s0 = sum; stable = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            a = $urandom; b = $urandom; sub = ~sub;
            if (sum !== s0 || done !== 1'b0 || busy !== 1'b0) stable = 1'b0;
        end
        chk("idle_stable", stable, 1);

        // Reset mid-operation
        @(negedge clk);
        launch(32'h12345678, 32'h11111111, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_sum", sum, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_cout", cout, 0);
        chk("midrst_ovf", overflow, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done !== 1'b0) seen = 1'b1;
        end
        chk("midrst_no_done", seen, 0);
        run_op(32'h12345678, 32'h11111111, 1'b0, 0, n, bok);
        chk("postrst_sum", sum, 32'h23456789);
        chk("postrst_lat", n, 8);

        // Random, WIDTH = 32
        for (int i = 0; i < 2000; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            bb  = rs ? ~rb : rb;
            mdl = {1'b0, ra} + {1'b0, bb} + 33'(rs);
            rov = (ra[31] == bb[31]) && (mdl[31] != ra[31]);
            run_op(ra, rb, rs, 0, n, bok);
            chk("rnd32_lat", n, 8);
            chk("rnd32_sum", sum, mdl[31:0]);
            chk("rnd32_cout", cout, mdl[32]);
            chk("rnd32_ovf", overflow, rov);
        end

        // Random, WIDTH = 8 and 16 running side by side
        @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            a_s = 16'($urandom); b_s = 16'($urandom); sub_s = 1'($urandom_range(0, 1));
            bb8   = sub_s ? ~b_s[7:0] : b_s[7:0];
            bb16  = sub_s ? ~b_s : b_s;
            e8    = {1'b0, a_s[7:0]} + {1'b0, bb8} + 9'(sub_s);
            e16   = {1'b0, a_s} + {1'b0, bb16} + 17'(sub_s);
            eov8  = (a_s[7] == bb8[7]) && (e8[7] != a_s[7]);
            eov16 = (a_s[15] == bb16[15]) && (e16[15] != a_s[15]);
            start_s = 1'b1;
            @(posedge clk); #1;
            start_s = 1'b0;
            l8 = 0; l16 = 0;
            for (int k = 1; k <= 6; k++) begin
                @(posedge clk); #1;
                if (done8 === 1'b1) begin
                    l8 = k;
                    chk("rnd8_sum", sum8, e8[7:0]);
                    chk("rnd8_cout", cout8, e8[8]);
                    chk("rnd8_ovf", ov8, eov8);
                end
                if (done16 === 1'b1) begin
                    l16 = k;
                    chk("rnd16_sum", sum16, e16[15:0]);
                    chk("rnd16_cout", cout16, e16[16]);
                    chk("rnd16_ovf", ov16, eov16);
                end
            end
            chk("rnd8_lat", l8, 2);
            chk("rnd16_lat", l16, 4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
